// File: rtl/pipelined_csa_adder.sv
// Carry-select adder/subtractor with valid/ready handshakes on both sides.
// Operands are cut into SEG-bit segments: segment 0 ripples with the true
// carry-in, every higher segment precomputes both carry-in results and the
// incoming carry picks one. With SPLIT > 0 a register cut sits at segment
// boundary SPLIT, so the carry out of segment SPLIT-1 is registered and the
// upper segments are resolved one cycle later.

// One carry-select segment: both candidate sums and carry-outs.
module csa_seg #(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  output logic [SEG-1:0] s0,
  output logic [SEG-1:0] s1,
  output logic           c0,
  output logic           c1
);
  assign {c0, s0} = {1'b0, a} + {1'b0, b};
  assign {c1, s1} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, 1'b1};
endmodule

module pipelined_csa_adder #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8,
  parameter int SPLIT = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             overflow,
  output logic             zero
);
  localparam int NSEG   = WIDTH / SEG;
  localparam int STAGES = (SPLIT == 0) ? 1 : 2;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             co;
    logic             overflow;
    logic             zero;
  } res_t;

  if ((WIDTH % SEG) != 0 || NSEG < 2 || SPLIT < 0 || SPLIT >= NSEG) begin : g_bad_params
    $error("pipelined_csa_adder: illegal WIDTH/SEG/SPLIT combination");
  end

  // ---------------------------------------------------------------------
  // Operand prep: subtraction is a + ~b + 1, borrow-in inverts the carry.
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] b_eff;
  logic             c_first;

  assign b_eff = op[0] ? ~b : b;

  // Carry into segment 0 from the opcode and cin
  always_comb begin
    c_first = 1'b0;
    unique case (op)
      2'b00: c_first = 1'b0;
      2'b01: c_first = 1'b1;
      2'b10: c_first = cin;
      2'b11: c_first = ~cin;
      default: c_first = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Handshake: each stage loads when empty or when its content leaves.
  // ---------------------------------------------------------------------
  logic [STAGES:1] vld_pipe;
  logic            ld_first;
  logic            ld_last;
  logic            in_fire;
  logic            fin_fire;

  assign ld_last   = !vld_pipe[STAGES] || out_ready;
  assign in_ready  = ld_first && !reset;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = vld_pipe[STAGES];

  if (STAGES == 1) begin : g_vld1
    assign ld_first = ld_last;
    assign fin_fire = in_fire;

    // Single result stage follows the input handshake directly
    always_ff @(posedge clock) begin
      if (reset)        vld_pipe <= '0;
      else if (ld_last) vld_pipe[1] <= in_valid;
    end
  end else begin : g_vld2
    assign ld_first = !vld_pipe[1] || ld_last;
    assign fin_fire = vld_pipe[1] && ld_last;

    // Stage A fills from the input, stage B from stage A
    always_ff @(posedge clock) begin
      if (reset) begin
        vld_pipe <= '0;
      end else begin
        if (ld_first) vld_pipe[1]      <= in_valid;
        if (ld_last)  vld_pipe[STAGES] <= vld_pipe[1];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Segment array. seg_a/seg_b are the operands as seen by the stage that
  // resolves the segment; seg_f is the sum as seen by the result register.
  // ---------------------------------------------------------------------
  logic [NSEG-1:0][SEG-1:0] seg_a;
  logic [NSEG-1:0][SEG-1:0] seg_b;
  logic [NSEG-1:0][SEG-1:0] seg_r;
  logic [NSEG-1:0][SEG-1:0] seg_f;

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    logic ci;
    logic co;

    if (SPLIT > 0 && k >= SPLIT) begin : g_opnd_q
      logic [SEG-1:0] a_q;
      logic [SEG-1:0] b_q;

      // Upper operands wait in stage A until the cut carry is known
      always_ff @(posedge clock) begin
        if (in_fire) begin
          a_q <= a[k*SEG +: SEG];
          b_q <= b_eff[k*SEG +: SEG];
        end
      end

      assign seg_a[k] = a_q;
      assign seg_b[k] = b_q;
    end else begin : g_opnd
      assign seg_a[k] = a[k*SEG +: SEG];
      assign seg_b[k] = b_eff[k*SEG +: SEG];
    end

    if (k == 0) begin : g_ci_first
      assign ci = c_first;
    end else if (k == SPLIT) begin : g_ci_cut
      logic carry_q;

      // Carry crossing the pipeline cut
      always_ff @(posedge clock) begin
        if (in_fire) carry_q <= g_seg[k-1].co;
      end

      assign ci = carry_q;
    end else begin : g_ci_chain
      assign ci = g_seg[k-1].co;
    end

    if (k == 0) begin : g_ripple
      assign {co, seg_r[k]} = {1'b0, seg_a[k]} + {1'b0, seg_b[k]} + {{SEG{1'b0}}, ci};
    end else begin : g_select
      logic [SEG-1:0] s0;
      logic [SEG-1:0] s1;
      logic           c0;
      logic           c1;

      csa_seg #(.SEG(SEG)) u_seg (
        .a  (seg_a[k]),
        .b  (seg_b[k]),
        .s0 (s0),
        .s1 (s1),
        .c0 (c0),
        .c1 (c1)
      );

      assign seg_r[k] = ci ? s1 : s0;
      assign co       = ci ? c1 : c0;
    end

    if (k < SPLIT) begin : g_sum_q
      logic [SEG-1:0] sum_q;

      // Low sum bits resolved in stage A
      always_ff @(posedge clock) begin
        if (in_fire) sum_q <= seg_r[k];
      end

      assign seg_f[k] = sum_q;
    end else begin : g_sum
      assign seg_f[k] = seg_r[k];
    end
  end

  // ---------------------------------------------------------------------
  // Flags and result register
  // ---------------------------------------------------------------------
  res_t res_d;
  res_t res_q;
  logic carry_msb;

  // Carry into the MSB recovered from the MSB sum and operand bits
  always_comb begin
    res_d          = '0;
    res_d.s        = seg_f;
    res_d.co       = g_seg[NSEG-1].co;
    carry_msb      = res_d.s[WIDTH-1] ^ seg_a[NSEG-1][SEG-1] ^ seg_b[NSEG-1][SEG-1];
    res_d.overflow = carry_msb ^ res_d.co;
    res_d.zero     = ~|res_d.s;
  end

  // Result loads only when a beat enters the last stage, so it holds otherwise
  always_ff @(posedge clock) begin
    if (reset)         res_q <= '0;
    else if (fin_fire) res_q <= res_d;
  end

  assign s        = res_q.s;
  assign co       = res_q.co;
  assign overflow = res_q.overflow;
  assign zero     = res_q.zero;

endmodule

// File: tb/tb_pipelined_csa_adder.sv
// Scoreboard bench: one DUT per SPLIT in {0,1,2,3} (WIDTH=32, SEG=8), each
// with its own driver, out_ready generator and monitor. Expected results come
// from signed/unsigned integer arithmetic, not from segment logic.
module tb_pipelined_csa_adder;
  localparam int W    = 32;
  localparam int SEG  = 8;
  localparam int NCFG = 4;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    logic         z;
    int           cyc;
    bit           lat;
  } exp_t;

  logic            clk;
  int              n_tests = 0;
  int              n_fail  = 0;
  bit [NCFG-1:0]   done    = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: exact integer result, then wrap and derive flags
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic c);
    exp_t e;
    longint sx, sy, sr, k;
    longint unsigned ux, uy;
    k  = (o[1]) ? longint'({63'd0, c}) : 64'sd0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    if (!o[0]) begin
      sr   = sx + sy + k;
      e.co = ((ux + uy + longint'(k)) >= 64'h1_0000_0000);
    end else begin
      sr   = sx - sy - k;
      e.co = (ux >= uy + longint'(k));
    end
    e.s   = sr[W-1:0];
    e.ov  = (sr > SMAX) || (sr < SMIN);
    e.z   = (e.s == '0);
    e.cyc = 0;
    e.lat = 1'b0;
    return e;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return W'($urandom);
    endcase
  endfunction

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int STAGES = (g == 0) ? 1 : 2;

    logic         reset, in_valid, in_ready, cin, out_valid, out_ready, co, overflow, zero;
    logic [1:0]   op;
    logic [W-1:0] a, b, s;
    exp_t         q[$];
    int           cyc     = 0;
    int           or_mode = 0;
    bit           lat_on  = 1'b0;

    pipelined_csa_adder #(.WIDTH(W), .SEG(SEG), .SPLIT(g)) dut (
      .clock     (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
      .co        (co),
      .overflow  (overflow),
      .zero      (zero)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
        n_fail++;
        $display("FAIL split%0d %s: got %0h, expected %0h", g, nm, act, req);
      end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // out_ready policy: 0 = always ready, 1 = stalled, 2 = random stalls
    initial begin
      out_ready = 1'b1;
      forever begin
        @(posedge clk); #1;
        case (or_mode)
          0:       out_ready = 1'b1;
          1:       out_ready = 1'b0;
          default: out_ready = ($urandom_range(99) >= 30);
        endcase
      end
    end

    // Monitor: reset state, hold under backpressure, ready rule, results
    logic         prev_rst  = 1'b0;
    logic         prev_hold = 1'b0;
    logic [W+2:0] prev_res  = '0;
    int           occ       = 0;

    always @(negedge clk) begin : mon
      exp_t e;
      if (prev_rst) begin
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_result", {29'd0, s, co, overflow, zero}, 64'd0);
      end
      if (prev_hold) begin
        chk("hold_out_valid", {63'd0, out_valid}, 64'd1);
        chk("hold_result", {29'd0, s, co, overflow, zero}, {29'd0, prev_res});
      end
      if (reset) begin
        chk("in_ready_in_reset", {63'd0, in_ready}, 64'd0);
        q.delete();
        occ = 0;
      end else begin
        chk("in_ready", {63'd0, in_ready}, {63'd0, (occ < STAGES) || out_ready});
        if (out_valid && out_ready) begin
          chk("beat_expected", {63'd0, q.size() > 0}, 64'd1);
          if (q.size() > 0) begin
            e = q.pop_front();
            chk("result", {29'd0, s, co, overflow, zero}, {29'd0, e.s, e.co, e.ov, e.z});
            if (e.lat) chk("latency", 64'(cyc - e.cyc), 64'(STAGES));
          end
        end
        occ = occ + int'(in_valid && in_ready) - int'(out_valid && out_ready);
      end
      prev_rst  = reset;
      prev_hold = !reset && out_valid && !out_ready;
      prev_res  = {s, co, overflow, zero};
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic beat(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic c);
      int n = 0;
      in_valid = 1'b1; op = o; a = x; b = y; cin = c;
      forever begin
        @(negedge clk);
        if (in_ready) begin
          exp_t e;
          e     = model(o, x, y, c);
          e.cyc = cyc;
          e.lat = lat_on;
          q.push_back(e);
          @(posedge clk); #1;
          break;
        end
        n++;
        if (n > 200) begin
          chk("accept_within_bound", {63'd0, in_ready}, 64'd1);
          @(posedge clk); #1;
          break;
        end
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
    endtask

    task automatic idle();
      @(posedge clk); #1;
    endtask

    task automatic drain();
      for (int i = 0; i < 100 && q.size() > 0; i++) idle();
      chk("drained", 64'(q.size()), 64'd0);
    endtask

    initial begin
      reset = 1'b1; in_valid = 1'b1; op = 2'b00; cin = 1'b0;
      a = 32'h1234_5678; b = 32'h1;      // beat offered during reset
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0; in_valid = 1'b0;

      // Directed corner cases at full rate, latency checked
      lat_on = 1'b1;
      beat(2'b00, 32'h0000_00FF, 32'h0000_0001, 1'b0);
      beat(2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
      beat(2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      beat(2'b01, 32'h0000_0005, 32'h0000_0007, 1'b0);
      beat(2'b11, 32'h0000_0007, 32'h0000_0005, 1'b1);
      beat(2'b10, 32'h00FF_FFFF, 32'h0000_0000, 1'b1);
      beat(2'b01, 32'h8000_0000, 32'h0000_0001, 1'b0);
      beat(2'b11, 32'h0000_0000, 32'h0000_0000, 1'b1);
      for (int i = 0; i < 8; i++) beat(2'b00, W'(i), W'(i) << 16, 1'b0);
      drain();
      lat_on = 1'b0;

      // Backpressure: fill every stage, then hold one more beat for 3+ cycles
      or_mode = 1;
      idle(); idle();
      for (int i = 0; i < STAGES; i++) beat(2'b00, W'(100 + i), W'(i) << 16, 1'b0);
      fork
        beat(2'b01, 32'h0000_0200, 32'h0000_0001, 1'b0);
        begin repeat (4) @(posedge clk); or_mode = 0; end
      join
      drain();

      // Random traffic with input gaps and output stalls
      or_mode = 2;
      for (int i = 0; i < 10000; i++) begin
        if ($urandom_range(3) == 0) idle();
        beat(2'($urandom_range(3)), pick(), pick(), 1'($urandom_range(1)));
      end
      or_mode = 0;
      drain();

      // Reset with beats in flight; a beat is offered during reset
      or_mode = 1;
      idle(); idle();
      for (int i = 0; i < STAGES; i++) beat(2'b00, pick(), pick(), 1'b0);
      reset = 1'b1; in_valid = 1'b1; a = 32'h5; b = 32'h6;
      @(posedge clk); #1;
      reset = 1'b0; in_valid = 1'b0; or_mode = 2;
      for (int i = 0; i < 20; i++) beat(2'($urandom_range(3)), pick(), pick(), 1'($urandom_range(1)));
      or_mode = 0;
      drain();
      done[g] = 1'b1;
    end
  end

  initial begin
    fork
      begin wait (done == '1); end
      begin repeat (90000) @(posedge clk); end
    join_any
    disable fork;
    n_tests++;
    if (done != '1) begin
      n_fail++;
      $display("FAIL completion: done=%b, expected all ones", done);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pipelined_csa_adder.md
Name: pipelined_csa_adder

Overview:
Parameterised, optionally two-stage pipelined carry-select adder/subtractor with valid/ready handshakes on both sides, for the ALU datapath.
Operands are split into equal segments. Segment 0 ripples with the true carry-in. Each higher segment computes both carry-in=0 and carry-in=1 results, and the real carry selects between them.
An optional pipeline cut at a segment boundary lets wide configurations close timing.
Flags: carry-out, signed overflow, zero.

Parameters:
WIDTH, 32, operand/result width; must be a multiple of SEG.
SEG, 8, bits per carry-select segment; NSEG = WIDTH/SEG, must be >= 2.
SPLIT, 0, segment index of the pipeline cut. 0 = single stage. 1..NSEG-1 = segments [SPLIT-1:0] are resolved in stage A and segments [NSEG-1:SPLIT] in stage B.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  operand beat valid
in_ready  out  1  block can accept a beat this cycle
op  in  2  00 add, 01 sub, 10 add-with-carry, 11 sub-with-borrow
a  in  WIDTH  operand A
b  in  WIDTH  operand B
cin  in  1  carry/borrow-in; used only for op 10/11
out_valid  out  1  result beat valid
out_ready  in  1  downstream accepts result
s  out  WIDTH  sum/difference
co  out  1  carry-out of MSB (sub: 1 = no borrow)
overflow  out  1  signed two's-complement overflow
zero  out  1  s == 0

Behaviour:
- Beat transfer: input occurs when in_valid && in_ready; output occurs when out_valid && out_ready.
- Operand prep:
  - b_eff = b for op 00/10; b_eff = ~b for op 01/11.
  - c0 = 0 (op 00), 1 (op 01), cin (op 10), ~cin (op 11; cin = borrow-in).
- Arithmetic:
  - Segment k>0 produces sums and carries for carry-in 0 and 1.
  - The selected carry of segment k-1 chooses the pair.
  - overflow = carry into MSB XOR co.
  - zero = ~|s.
  - All results are modulo 2^WIDTH.
- SPLIT = 0: one register stage.
  - Beat accepted at edge N appears on outputs with out_valid=1 after edge N.
  - Latency is 1 cycle.
- SPLIT > 0: two register stages.
  - Stage A registers: low sum bits, carry out of segment SPLIT-1, upper a/b_eff bits, valid.
  - Stage B selects the upper segments using the registered carry and registers the full result.
  - Latency is 2 cycles.
- Each stage register loads when it is empty or its contents are leaving this cycle:
  - load_X = !valid_X || advance_X.
  - in_ready = load of the first stage, combinationally including out_ready.
  - Full throughput is 1 beat/cycle with out_ready held high.
- Backpressure: with out_ready=0 and all stages full, in_ready=0. Held data and out_valid stay stable until accepted.
- Bubbles: a stage with valid=0 whose successor is free takes the next beat. No beat is dropped or duplicated.
- Simultaneous accept and emit on a full pipeline: both occur in the same cycle, and order is preserved.
- Result outputs (s, co, overflow, zero) are registered and held while out_valid=0. Their values are don't-care for checking when out_valid=0, except after reset.
- Reset, effective at the clock edge:
  - out_valid = 0; all stage valid bits = 0; s = 0; co = 0; overflow = 0; zero = 0.
  - in_ready = 1 in the cycle after reset deasserts.
  - In-flight beats are discarded. A beat presented during reset is not accepted.
  - in_ready is 0 while reset is high.
- Illegal parameters (WIDTH % SEG != 0, NSEG < 2, SPLIT >= NSEG): elaboration-time error.

Test Plan:
- WIDTH=32, SEG=8, SPLIT=0, op=00, a=32'h0000_00FF, b=32'h0000_0001 -> one cycle later s=32'h0000_0100, co=0, overflow=0, zero=0.
- SPLIT=2, op=00, a=32'h7FFF_FFFF, b=1 -> two cycles later s=32'h8000_0000, co=0, overflow=1. Then a=32'hFFFF_FFFF, b=1 -> s=0, co=1, zero=1, overflow=0.
- SPLIT=2, op=01, a=5, b=7 -> s=32'hFFFF_FFFE, co=0 (borrow), overflow=0. op=11, cin=1, a=7, b=5 -> s=1, co=1.
- SPLIT=2, stream 8 beats (a=i, b=i<<16) with out_ready=1 -> in_ready stays 1 and outputs arrive in order one per cycle. Drop out_ready for 3 cycles mid-stream -> in_ready falls once both stages are full, out_valid and s are held, and no beat is lost or duplicated.
- SPLIT=3, op=10, cin=1, a=32'h00FF_FFFF, b=0 -> s=32'h0100_0000. This exercises the carry across the cut and a select into the top segment.
- Assert reset with 2 beats in flight -> next cycle out_valid=0, s=0, flags=0, and no stale beat ever appears. Random add/sub against a reference model, 10k beats with random stalls, for SPLIT in {0,1,NSEG-1} -> zero mismatches.
